riscv_core_dpath_vec_alu_seq: RTL and testbench

Sequenced, parametrised vector ALU for the riscvvec datapath. It accepts one vector operation through a valid/ready request, processes LANES_PER_CYCLE elements per cycle up to the vector length, and returns the full result vector through a valid/ready response. The block sits in the X stage as a multi-cycle unit and stalls the pipeline via req_rdy/resp_val. It supersedes the single-cycle, fixed-8×32 vector ALU.

---
 rtl/riscv_core_dpath_vec_alu_seq.sv | 166 ++++++++++++++++
 tb/tb_riscv_core_dpath_vec_alu_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_dpath_vec_alu_seq.sv
// Sequenced vector ALU: one request, LANES_PER_CYCLE elements per busy cycle, full-vector response.
// Optional per-element write mask enabled by defining VECALU_MASK_EN (adds req_vmask).
module riscv_core_dpath_vec_alu_seq #(
  parameter int NELEM           = 8,
  parameter int ELEM_W          = 32,
  parameter int LANES_PER_CYCLE = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic [3:0]                req_fn,
  input  logic [$clog2(NELEM):0]    req_vl,
  input  logic [NELEM*ELEM_W-1:0]   req_vin0,
  input  logic [NELEM*ELEM_W-1:0]   req_vin1,
  input  logic [ELEM_W-1:0]         req_in0,
  input  logic                      req_in0_ven,
  input  logic [ELEM_W-1:0]         req_in1,
  input  logic                      req_in1_ven,
  input  logic [NELEM*ELEM_W-1:0]   req_vd_old,
`ifdef VECALU_MASK_EN
  input  logic [NELEM-1:0]          req_vmask,
`endif
  output logic                      resp_val,
  input  logic                      resp_rdy,
  output logic [NELEM*ELEM_W-1:0]   resp_vout,
  output logic [ELEM_W-1:0]         resp_out
);

  localparam int          VLW    = $clog2(NELEM) + 1;
  localparam int unsigned LPC    = LANES_PER_CYCLE;
  localparam int          NCHUNK = NELEM / LANES_PER_CYCLE;
  localparam int          CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [3:0] {
    FN_ADD = 4'd0, FN_SUB = 4'd1, FN_SLT = 4'd4, FN_SEQ = 4'd12, FN_VID = 4'd13
  } fn_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             chunk_q, chunk_d;
  logic [3:0]                fn_q;
  logic [VLW-1:0]            vl_q, vl_in;
  logic [NELEM*ELEM_W-1:0]   vin0_q, vin1_q;
  logic [ELEM_W-1:0]         in0_q, in1_q;
  logic                      in0_ven_q, in1_ven_q;
  logic [NELEM*ELEM_W-1:0]   res_q, res_d;
  logic [NELEM-1:0]          wmask;
  logic                      fire, last_chunk;
  logic [ELEM_W-1:0]         lane_a [LPC];
  logic [ELEM_W-1:0]         lane_b [LPC];
  logic [ELEM_W-1:0]         lane_e [LPC];
  logic [ELEM_W-1:0]         lane_r [LPC];

  assign req_rdy   = (state_q == IDLE);
  assign resp_val  = (state_q == DONE);
  assign resp_vout = res_q;
  assign resp_out  = res_q[ELEM_W-1:0];
  assign fire      = req_val && req_rdy;
  assign vl_in     = (req_vl > VLW'(NELEM)) ? VLW'(NELEM) : req_vl;

`ifdef VECALU_MASK_EN
  logic [NELEM-1:0] vmask_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vmask_q <= '0;
    else if (fire) vmask_q <= req_vmask;
  end
  always_comb wmask = vmask_q;
`else
  always_comb wmask = '1;
`endif

  // Steer the current chunk's operands onto LANES_PER_CYCLE shared ALU lanes.
  always_comb begin
    for (int unsigned l = 0; l < LPC; l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
      lane_e[l] = '0;
    end
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      if (chunk_q == CW'(c)) begin
        for (int unsigned l = 0; l < LPC; l++) begin
          lane_a[l] = in0_ven_q ? vin0_q[(c*LPC+l)*ELEM_W +: ELEM_W] : in0_q;
          lane_b[l] = in1_ven_q ? vin1_q[(c*LPC+l)*ELEM_W +: ELEM_W] : in1_q;
          lane_e[l] = ELEM_W'(c*LPC + l);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LPC; l++) begin
      lane_r[l] = '0;
      case (fn_q)
        FN_ADD:  lane_r[l] = lane_a[l] + lane_b[l];
        FN_SUB:  lane_r[l] = lane_a[l] - lane_b[l];
        FN_SLT:  lane_r[l][0] = $signed(lane_a[l]) < $signed(lane_b[l]);
        FN_SEQ:  lane_r[l][0] = (lane_a[l] == lane_b[l]);
        FN_VID:  lane_r[l] = lane_e[l];
        default: lane_r[l] = '0;
      endcase
    end
  end

  assign last_chunk = ((32'(chunk_q) + 32'd1) * LPC) >= 32'(vl_q);

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (req_val) begin
          res_d   = req_vd_old;
          chunk_d = '0;
          state_d = (vl_in == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        for (int unsigned c = 0; c < NCHUNK; c++) begin
          for (int unsigned l = 0; l < LPC; l++) begin
            if (chunk_q == CW'(c) && (c*LPC + l) < 32'(vl_q) && wmask[c*LPC + l])
              res_d[(c*LPC+l)*ELEM_W +: ELEM_W] = lane_r[l];
          end
        end
        chunk_d = chunk_q + CW'(1);
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        if (resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      chunk_q   <= '0;
      res_q     <= '0;
      fn_q      <= '0;
      vl_q      <= '0;
      vin0_q    <= '0;
      vin1_q    <= '0;
      in0_q     <= '0;
      in1_q     <= '0;
      in0_ven_q <= 1'b0;
      in1_ven_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      res_q   <= res_d;
      if (fire) begin
        fn_q      <= req_fn;
        vl_q      <= vl_in;
        vin0_q    <= req_vin0;
        vin1_q    <= req_vin1;
        in0_q     <= req_in0;
        in1_q     <= req_in1;
        in0_ven_q <= req_in0_ven;
        in1_ven_q <= req_in1_ven;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_dpath_vec_alu_seq.sv
// Scoreboard bench for riscv_core_dpath_vec_alu_seq: directed requests push expected vectors,
// a monitor pops and compares on every accepted response.
module tb_riscv_core_dpath_vec_alu_seq;
  localparam int NE = 8;
  localparam int W  = 32;
  localparam int VB = NE * W;

  typedef struct {
    logic [VB-1:0] vout;
    int unsigned   lat;
    int unsigned   fire_cyc;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_val, req_rdy, req_in0_ven, req_in1_ven;
  logic [3:0]    req_fn;
  logic [3:0]    req_vl;
  logic [VB-1:0] req_vin0, req_vin1, req_vd_old;
  logic [W-1:0]  req_in0, req_in1;
  logic [NE-1:0] req_vmask;
  logic          resp_val, resp_rdy;
  logic [VB-1:0] resp_vout;
  logic [W-1:0]  resp_out;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned rise_cyc = 0;

  riscv_core_dpath_vec_alu_seq #(.NELEM(NE), .ELEM_W(W), .LANES_PER_CYCLE(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn), .req_vl(req_vl),
    .req_vin0(req_vin0), .req_vin1(req_vin1),
    .req_in0(req_in0), .req_in0_ven(req_in0_ven),
    .req_in1(req_in1), .req_in1_ven(req_in1_ven),
    .req_vd_old(req_vd_old),
`ifdef VECALU_MASK_EN
    .req_vmask(req_vmask),
`endif
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_vout(resp_vout), .resp_out(resp_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VB-1:0] got, input logic [VB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  task automatic drive(input logic [3:0] fn, input logic [3:0] vl,
                       input logic [VB-1:0] a, input logic [VB-1:0] b,
                       input logic [W-1:0] s0, input logic v0,
                       input logic [W-1:0] s1, input logic v1,
                       input logic [VB-1:0] vd, input logic [NE-1:0] vm);
    req_fn = fn; req_vl = vl; req_vin0 = a; req_vin1 = b;
    req_in0 = s0; req_in0_ven = v0; req_in1 = s1; req_in1_ven = v1;
    req_vd_old = vd; req_vmask = vm; req_val = 1'b1;
  endtask

  // Expectation is queued on the negedge before the accepting edge; fire_cyc is that edge's index.
  task automatic wait_fire(input logic [VB-1:0] ex, input int unsigned lat, input string name);
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (req_rdy) break;
      n++;
      if (n > 100) begin
        req_val = 1'b0;
        timeout({name, "_fire"});
        return;
      end
    end
    sb.push_back('{ex, lat, cyc + 1, name});
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic issue(input logic [3:0] fn, input logic [3:0] vl,
                       input logic [VB-1:0] a, input logic [VB-1:0] b,
                       input logic [W-1:0] s0, input logic v0,
                       input logic [W-1:0] s1, input logic v1,
                       input logic [VB-1:0] vd, input logic [NE-1:0] vm,
                       input logic [VB-1:0] ex, input int unsigned lat, input string name);
    @(posedge clk); #1;
    drive(fn, vl, a, b, s0, v0, s1, v1, vd, vm);
    wait_fire(ex, lat, name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    timeout({name, "_drain"});
  endtask

  // Monitor: compare every accepted response against the oldest expectation.
  initial begin
    bit   prev;
    exp_t x;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev = 1'b0;
      else begin
        if (resp_val && !prev) rise_cyc = cyc;
        prev = resp_val;
        if (resp_val && resp_rdy) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got vout %h, required no response", resp_vout);
          end else begin
            x = sb.pop_front();
            check({x.name, "_vout"}, resp_vout, x.vout);
            check({x.name, "_out"}, VB'(resp_out), VB'(x.vout[W-1:0]));
            check({x.name, "_lat"}, VB'(rise_cyc - x.fire_cyc), VB'(x.lat));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VB-1:0] a, b, vd, ex, ex2;
    reset_n = 1'b0; req_val = 1'b0; resp_rdy = 1'b1;
    drive(4'd0, 4'd0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    req_val = 1'b0;
    #12;
    check("rst_resp_val", VB'(resp_val), VB'(1'b0));
    check("rst_req_rdy", VB'(req_rdy), VB'(1'b1));
    check("rst_vout", resp_vout, '0);
    @(posedge clk); #1 reset_n = 1'b1;

    // ADD vector-vector, full length
    for (int e = 0; e < NE; e++) begin
      a[e*W +: W] = 32'(e); b[e*W +: W] = 32'(10*e); ex[e*W +: W] = 32'(11*e);
    end
    issue(4'd0, 4'd8, a, b, '0, 1'b1, '0, 1'b1, '0, '1, ex, 4, "add_vv");
    wait_drain("add_vv");

    // SUB with broadcast scalar, partial length
    for (int e = 0; e < NE; e++) begin
      a[e*W +: W] = 32'(100 + e); vd[e*W +: W] = 32'hDEADBEEF;
    end
    ex = vd;
    ex[0*W +: W] = 32'd99; ex[1*W +: W] = 32'd100; ex[2*W +: W] = 32'd101;
    issue(4'd1, 4'd3, a, '0, '0, 1'b1, 32'd1, 1'b0, vd, '1, ex, 2, "sub_vs");
    wait_drain("sub_vs");

    // SLT across the signed overflow boundary
    for (int e = 0; e < NE; e++) begin
      a[e*W +: W] = 32'h80000000; ex[e*W +: W] = 32'd1;
    end
    issue(4'd4, 4'd8, a, '0, '0, 1'b1, 32'h7FFFFFFF, 1'b0, '0, '1, ex, 4, "slt_ovf");
    wait_drain("slt_ovf");

    // SEQ with identical operands
    for (int e = 0; e < NE; e++) begin
      a[e*W +: W] = 32'(3*e + 5); ex[e*W +: W] = 32'd1;
    end
    issue(4'd12, 4'd8, a, a, '0, 1'b1, '0, 1'b1, 32'hFFFF_FFFF, '1, ex, 4, "seq_eq");
    wait_drain("seq_eq");

    // VID, vl=5: odd tail chunk writes only lane 0
    for (int e = 0; e < NE; e++) begin
      vd[e*W +: W] = 32'hAAAA0000 + 32'(e);
      ex[e*W +: W] = (e < 5) ? 32'(e) : vd[e*W +: W];
    end
    issue(4'd13, 4'd5, '0, '0, '0, 1'b0, '0, 1'b0, vd, '1, ex, 3, "vid_vl5");
    wait_drain("vid_vl5");

    // Reserved opcode zeroes active elements
    for (int e = 0; e < NE; e++) begin
      a[e*W +: W] = 32'(7 + e); vd[e*W +: W] = 32'h0BAD0000 + 32'(e);
    end
    issue(4'd7, 4'd8, a, a, '0, 1'b1, '0, 1'b1, vd, '1, '0, 4, "rsvd_fn");
    wait_drain("rsvd_fn");

    // vl above NELEM clamps to NELEM
    for (int e = 0; e < NE; e++) ex[e*W +: W] = 32'(e);
    issue(4'd13, 4'd15, '0, '0, '0, 1'b0, '0, 1'b0, '1, '1, ex, 4, "vid_clamp");
    wait_drain("vid_clamp");

    // vl=0 with consumer stalled; a second request must wait for resp_rdy
    for (int e = 0; e < NE; e++) vd[e*W +: W] = 32'h12340000 + 32'(e);
    @(posedge clk); #1 resp_rdy = 1'b0;
    issue(4'd0, 4'd0, a, a, '0, 1'b1, '0, 1'b1, vd, '1, vd, 0, "vl0_hold");
    ex2 = '0; ex2[0 +: W] = 32'd12;
    drive(4'd0, 4'd1, '0, '0, 32'd5, 1'b0, 32'd7, 1'b0, '0, '1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_resp_val", VB'(resp_val), VB'(1'b1));
      check("hold_req_rdy", VB'(req_rdy), VB'(1'b0));
      check("hold_vout", resp_vout, vd);
    end
    @(posedge clk); #1 resp_rdy = 1'b1;
    wait_fire(ex2, 1, "add_ss_vl1");
    wait_drain("add_ss_vl1");

    // Reset in the 2nd BUSY cycle discards the op
    for (int e = 0; e < NE; e++) begin
      a[e*W +: W] = 32'(e); b[e*W +: W] = 32'(10*e); ex[e*W +: W] = 32'(11*e);
    end
    issue(4'd0, 4'd8, a, b, '0, 1'b1, '0, 1'b1, '0, '1, ex, 4, "rst_victim");
    @(posedge clk); #2;
    check("busy_before_rst", VB'(req_rdy), VB'(1'b0));
    reset_n = 1'b0;
    #1;
    check("midrst_resp_val", VB'(resp_val), VB'(1'b0));
    check("midrst_req_rdy", VB'(req_rdy), VB'(1'b1));
    check("midrst_vout", resp_vout, '0);
    check("midrst_out", VB'(resp_out), '0);
    sb.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    for (int e = 0; e < NE; e++) begin
      b[e*W +: W] = 32'(e); ex[e*W +: W] = 32'(e) - 32'd1;
    end
    issue(4'd0, 4'd8, '0, b, 32'hFFFFFFFF, 1'b0, '0, 1'b1, '0, '1, ex, 4, "add_after_rst");
    wait_drain("add_after_rst");

`ifdef VECALU_MASK_EN
    for (int e = 0; e < NE; e++) begin
      a[e*W +: W] = 32'(e); b[e*W +: W] = 32'(10*e); vd[e*W +: W] = 32'h55550000 + 32'(e);
      ex[e*W +: W] = (e == 0 || e == 2 || e == 5 || e == 7) ? 32'(11*e) : vd[e*W +: W];
    end
    issue(4'd0, 4'd8, a, b, '0, 1'b1, '0, 1'b1, vd, 8'b1010_0101, ex, 4, "add_mask");
    wait_drain("add_mask");
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", VB'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
